instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter INS_ADDRESS, default 9, SHALL be the instruction-memory word-address width.
REQ-002 Parameter PC_WIDTH, default 32, SHALL be the byte-address PC width.
REQ-003 Parameter INSTR_WIDTH, default 32, SHALL be the instruction word width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 pc  in  PC_WIDTH  SHALL be the current byte PC from the program counter.
REQ-007 pc_advance  out  1  SHALL pulse high for each cycle in which pc is consumed; this is the PC step enable.
REQ-008 imem_req  out  1  SHALL be the read request to instruction memory.
REQ-009 imem_addr  out  INS_ADDRESS  SHALL equal pc[INS_ADDRESS+1:2], the word address.
REQ-010 imem_rvalid  in  1  SHALL indicate imem_rdata holds the response to the outstanding request.
REQ-011 imem_rdata  in  INSTR_WIDTH  SHALL be the returned instruction word.
REQ-012 flush  in  1  SHALL discard all fetched and in-flight instructions (branch taken or redirect).
REQ-013 id_ready  in  1  SHALL indicate decode accepts the head entry this cycle.
REQ-014 if_valid  out  1  SHALL indicate if_instr, if_pc and if_misalign are valid.
REQ-015 if_instr  out  INSTR_WIDTH  SHALL be the head-entry instruction.
REQ-016 if_pc  out  PC_WIDTH  SHALL be the head-entry PC.
REQ-017 if_misalign  out  1  SHALL be set when the head-entry PC has pc[1:0] != 0.

Function
REQ-018 The block SHALL hold a 2-entry FIFO of {pc, instr, misalign}; the head drives the if_* outputs.
REQ-019 The FSM SHALL have the states FETCH, WAIT and DROP, with at most one memory request outstanding.
REQ-020 In FETCH, imem_req SHALL equal (count < 2) AND NOT flush, where count is the FIFO occupancy after any pop in the same cycle.
REQ-021 pc_advance SHALL equal imem_req; the issued pc SHALL be latched in a request register.
REQ-022 FETCH SHALL go to WAIT on imem_req; WAIT SHALL go to FETCH on imem_rvalid, pushing {latched pc, imem_rdata, latched pc[1:0] != 0}.
REQ-023 If flush occurs in WAIT without imem_rvalid, the FSM SHALL go to DROP.
REQ-024 In DROP, the first imem_rvalid SHALL be discarded and the FSM SHALL return to FETCH.
REQ-025 If flush and imem_rvalid occur together in WAIT, the response SHALL be discarded and the next state SHALL be FETCH.
REQ-026 flush SHALL empty the FIFO on the same edge, and SHALL take priority over both push and pop.
REQ-027 if_valid SHALL be (count != 0); a pop SHALL occur when if_valid AND id_ready AND NOT flush.
REQ-028 Push and pop in the same cycle SHALL keep count unchanged.
REQ-029 The FIFO SHALL never overflow; imem_rvalid in FETCH is a protocol error and SHALL be ignored.
REQ-030 Latency: a request issued in cycle N with rvalid in cycle N+1 SHALL give if_valid in cycle N+2.
REQ-031 if_* outputs SHALL hold stable while if_valid is high and id_ready is low.
REQ-032 Sustained throughput with 1-cycle memory and id_ready held high SHALL be one instruction per 2 cycles.

Reset
REQ-033 On reset, the state SHALL be FETCH, the FIFO empty, if_valid=0, and imem_req=0 and pc_advance=0 during the reset cycle.
REQ-034 On reset, if_instr, if_pc and the request register SHALL be 0.
REQ-035 A response arriving after reset released SHALL be ignored, because the state is FETCH.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, the NOP instruction constant and the FIFO depth constant (2).
REQ-037 The FIFO SHALL be a sub-module named fetch_fifo, parameterised by data width and depth.

Verification
REQ-038 Scenario: reset, pc=0x0, 1-cycle memory returning 0x00500093, id_ready=1 -> req in cycle 1, if_valid in cycle 3 with if_pc=0x0 and if_instr=0x00500093.
REQ-039 Scenario: id_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req low afterwards, and outputs stable.
REQ-040 Scenario: flush in WAIT, then rvalid with 0xDEADBEEF one cycle later -> word dropped, if_valid=0, and a new request in the following cycle.
REQ-041 Scenario: flush and rvalid in the same cycle with the FIFO full -> FIFO empty and state FETCH next cycle.
REQ-042 Scenario: pc=0x6 -> imem_addr=1, and the entry shows if_misalign=1.
REQ-043 Scenario: reset asserted while in WAIT, then rvalid after release -> response ignored and if_valid stays 0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam int          FIFO_DEPTH = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register FIFO; entry 0 is always the head, so the head is a plain register read.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_ap;
    logic [AW-1:0]    wr_idx;
    logic             pop_ok;

    assign pop_ok   = pop && (count != '0);
    assign count_ap = count - CW'(pop_ok);
    assign wr_idx   = AW'(count_ap);
    assign head     = mem[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            if (pop_ok)
                for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            // write lands after the shift, so a same-cycle push/pop fills the freed slot
            if (push && (count_ap < CW'(DEPTH))) begin
                mem[wr_idx] <= push_data;
                count       <= count_ap + CW'(1);
            end else begin
                count <= count_ap;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem read, 2-entry output queue, flush-safe response dropping.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int INS_ADDRESS = 9,
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic                   pc_advance,
    output logic                   imem_req,
    output logic [INS_ADDRESS-1:0] imem_addr,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   flush,
    input  logic                   id_ready,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic                   if_misalign
);
    localparam int EW = PC_WIDTH + INSTR_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t          state, state_nxt;
    logic [PC_WIDTH-1:0]   req_pc;
    logic [CW-1:0]         count, count_ap;
    logic                  push, pop;
    logic [EW-1:0]         head;

    assign if_valid  = (count != '0);
    assign pop       = if_valid && id_ready && !flush;
    assign count_ap  = count - CW'(pop);
    assign push      = (state == WAIT) && imem_rvalid && !flush;
    assign imem_addr = pc[INS_ADDRESS+1:2];

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset)         req_pc <= '0;
        else if (imem_req) req_pc <= pc;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: if (imem_req) state_nxt = WAIT;
            // a flush racing the response drops it and skips DROP
            WAIT:  if (flush)            state_nxt = imem_rvalid ? FETCH : DROP;
                   else if (imem_rvalid) state_nxt = FETCH;
            DROP:  if (imem_rvalid) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        if (!reset && (state == FETCH) && !flush && (count_ap < CW'(FIFO_DEPTH)))
            imem_req = 1'b1;
    end

    assign pc_advance = imem_req;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data ({req_pc, imem_rdata, (req_pc[1:0] != 2'b00)}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign if_pc       = head[EW-1 -: PC_WIDTH];
    assign if_instr    = head[INSTR_WIDTH:1];
    assign if_misalign = head[0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: reactive memory model plus an expected-entry queue for the fetch output.
module tb_instr_fetch;
    localparam int IA = 9, PW = 32, IW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] pc = '0;
    logic          pc_advance, imem_req;
    logic [IA-1:0] imem_addr;
    logic          imem_rvalid = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic          flush = 1'b0, id_ready = 1'b1;
    logic          if_valid, if_misalign;
    logic [IW-1:0] if_instr;
    logic [PW-1:0] if_pc;

    always #5 clk = ~clk;

    instr_fetch #(.INS_ADDRESS(IA), .PC_WIDTH(PW), .INSTR_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_advance(pc_advance),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .flush(flush), .id_ready(id_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_misalign(if_misalign)
    );

    typedef struct { logic [31:0] pc; logic [31:0] ins; logic mis; } ent_t;
    ent_t q[$];

    int total = 0, bad = 0;
    int lat = 1, pend = 0, npop = 0;
    logic [31:0] pend_pc = '0, pc_nxt = '0, redirect = '0;
    bit taint = 0, ghost = 0, bad_word = 0;
    bit last_req = 0;
    logic [IA-1:0] last_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [IA-1:0] a);
        return {a, 23'h0} ^ 32'h0050_0093;
    endfunction

    // one clock cycle: drive at negedge, check 1ns later, then advance the model
    task automatic cyc(input bit fl, input bit rdy, input bit rst);
        bit   resp, outst, exp_req;
        int   qn;
        ent_t e;
        @(negedge clk);
        pc = pc_nxt;
        flush = fl; id_ready = rdy; reset = rst;
        imem_rvalid = 1'b0; imem_rdata = '0; resp = 0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                resp = 1; imem_rvalid = 1'b1;
                imem_rdata = bad_word ? 32'hDEAD_BEEF : mem_word(pend_pc[IA+1:2]);
            end
        end
        if ((fl || rst) && (pend > 0 || resp)) taint = 1;
        if (rst && (pend > 0 || resp)) ghost = 1;
        outst = (pend > 0 || resp) && !ghost;
        #1;
        qn = q.size();
        if (!rst) begin
            chk("vld", if_valid, qn != 0);
            if (qn != 0 && if_valid) begin
                chk("ipc", if_pc, q[0].pc);
                chk("ins", if_instr, q[0].ins);
                chk("mis", if_misalign, q[0].mis);
            end
            exp_req = !fl && !outst && ((qn - ((qn != 0 && rdy) ? 1 : 0)) < 2);
            chk("req", imem_req, exp_req);
            chk("adv", pc_advance, imem_req);
            chk("addr", imem_addr, pc[IA+1:2]);
        end
        last_req = imem_req; last_addr = imem_addr;
        if (rst || fl) q.delete();
        else begin
            if (qn != 0 && rdy) begin void'(q.pop_front()); npop++; end
            if (resp && !taint) begin
                e.pc = pend_pc; e.ins = imem_rdata; e.mis = (pend_pc[1:0] != 2'b00);
                q.push_back(e);
            end
        end
        if (resp) begin taint = 0; ghost = 0; end
        if (imem_req && !rst) begin pend = lat; pend_pc = pc; pc_nxt = pc + 4; end
        if (fl) pc_nxt = redirect;
    endtask

    task automatic wait_req(input bit rdy);
        int g = 0;
        do begin cyc(0, rdy, 0); g++; end while (!last_req && g < 20);
        if (!last_req) chk("req_tmo", 0, 1);
    endtask

    initial begin
        int p0;
        // reset
        cyc(0, 1, 1);
        chk("rst_req", imem_req, 0);
        chk("rst_adv", pc_advance, 0);
        chk("rst_vld", if_valid, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_ins", if_instr, 0);

        // first fetch latency and throughput
        cyc(0, 1, 0); chk("c1_req", imem_req, 1);
        cyc(0, 1, 0); chk("c2_rv", imem_rvalid, 1);
        cyc(0, 1, 0);
        chk("c3_vld", if_valid, 1);
        chk("c3_pc", if_pc, 32'h0);
        chk("c3_ins", if_instr, 32'h0050_0093);
        p0 = npop;
        repeat (20) cyc(0, 1, 0);
        chk("thru", npop - p0, 10);

        // decode stall: queue fills and requests stop
        repeat (10) cyc(0, 0, 0);
        chk("stl_req", imem_req, 0);
        chk("stl_vld", if_valid, 1);
        repeat (6) cyc(0, 1, 0);

        // flush in WAIT, late response is dropped
        lat = 2; redirect = 32'h100;
        wait_req(1);
        cyc(1, 1, 0);
        bad_word = 1;
        cyc(0, 1, 0);
        bad_word = 0;
        chk("drp_rv", imem_rvalid, 1);
        chk("drp_vld", if_valid, 0);
        chk("drp_req", imem_req, 0);
        cyc(0, 1, 0);
        chk("drp_new", imem_req, 1);
        repeat (4) cyc(0, 1, 0);

        // flush coincident with response, queue loaded
        lat = 1; redirect = 32'h200;
        repeat (8) cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("ff_req", imem_req, 1);
        cyc(1, 0, 0);
        chk("ff_rv", imem_rvalid, 1);
        cyc(0, 1, 0);
        chk("ff_vld", if_valid, 0);
        chk("ff_fetch", imem_req, 1);
        repeat (4) cyc(0, 1, 0);

        // misaligned PC
        redirect = 32'h6;
        cyc(1, 0, 0);
        wait_req(0);
        chk("mis_addr", last_addr, 1);
        repeat (3) cyc(0, 0, 0);
        chk("mis_vld", if_valid, 1);
        chk("mis_flag", if_misalign, 1);
        chk("mis_pc", if_pc, 32'h6);
        repeat (6) cyc(0, 1, 0);

        // reset while a request is outstanding
        lat = 2;
        wait_req(1);
        cyc(0, 1, 1);
        cyc(0, 1, 0);
        chk("rw_rv", imem_rvalid, 1);
        chk("rw_vld0", if_valid, 0);
        cyc(0, 1, 0);
        chk("rw_vld1", if_valid, 0);
        cyc(0, 1, 0);
        chk("rw_vld2", if_valid, 0);
        repeat (8) cyc(0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
